ahb_resp_mux_s5: RTL and testbench

AHB_RESP_MUX_S5 -- requirements
Module: ahb_resp_mux_s5

---
 rtl/ahb_pkg.sv | 44 ++++
 rtl/ahb_default_slave.sv | 63 ++++++
 rtl/ahb_resp_mux_s5.sv | 129 ++++++++++++
 tb/tb_ahb_resp_mux_s5.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared encodings for the AHB response mux: transfer types, response codes,
// slave count and the registered data-phase select.
// Pure definitions, no logic; imported by the mux and its default slave.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Four real slaves plus the internal default slave on the last index.
  localparam int NUM_SLAVES = 5;

  typedef enum logic [2:0] {
    DSEL_S0   = 3'd0,
    DSEL_S1   = 3'd1,
    DSEL_S2   = 3'd2,
    DSEL_S3   = 3'd3,
    DSEL_DEF  = 3'd4,
    DSEL_NONE = 3'd7
  } dsel_e;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  // Lowest asserted select wins; nothing asserted means no data phase owner.
  function automatic dsel_e resolve_sel(input logic [NUM_SLAVES-1:0] sel);
    dsel_e r;
    r = DSEL_NONE;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (sel[i]) r = dsel_e'(3'(i));
    end
    return r;
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped addresses: two-cycle ERROR for active transfers.
// Latency: IDLE/BUSY answered zero-wait OKAY; NONSEQ/SEQ get ERR1 (wait) then ERR2.
// Backpressure: only samples a new transfer when hready_in=1; never times out.
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       sel,
  input  logic [1:0] htrans,
  input  logic       hready_in,
  output logic       hreadyout,
  output logic       hresp
);

  ds_state_e state;
  logic      start;

  // An active transfer addressed to us and accepted by the bus this cycle.
  assign start = sel && hready_in &&
                 ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));

  // Error-response FSM with outputs registered alongside the state.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= DS_IDLE;
      hreadyout <= 1'b1;
      hresp     <= HRESP_OKAY;
    end else begin
      case (state)
        DS_IDLE: begin
          if (start) begin
            state     <= DS_ERR1;
            hreadyout <= 1'b0;
            hresp     <= HRESP_ERROR;
          end
        end
        DS_ERR1: begin
          state     <= DS_ERR2;
          hreadyout <= 1'b1;
          hresp     <= HRESP_ERROR;
        end
        DS_ERR2: begin
          if (start) begin
            state     <= DS_ERR1;
            hreadyout <= 1'b0;
            hresp     <= HRESP_ERROR;
          end else begin
            state     <= DS_IDLE;
            hreadyout <= 1'b1;
            hresp     <= HRESP_OKAY;
          end
        end
        default: begin
          state     <= DS_IDLE;
          hreadyout <= 1'b1;
          hresp     <= HRESP_OKAY;
        end
      endcase
    end
  end

endmodule

// File: rtl/ahb_resp_mux_s5.sv
// AHB data-phase response mux for four slaves plus an internal default slave.
// Latency: zero added; outputs follow the slave latched at the last HREADY=1 edge.
// Backpressure: a slave holding HREADYOUT low stalls the bus indefinitely.
// Optional AHB_MUX_ERRCNT_EN adds a saturating default-slave error counter (ERRCNT/ERRCLR).
module ahb_resp_mux_s5
  import ahb_pkg::*;
#(
  parameter int DW = 32
)
(
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSEL0,
  input  logic          HSEL1,
  input  logic          HSEL2,
  input  logic          HSEL3,
  input  logic          HSEL4,
  input  logic [1:0]    HTRANS,
  input  logic [DW-1:0] HRDATA0,
  input  logic [DW-1:0] HRDATA1,
  input  logic [DW-1:0] HRDATA2,
  input  logic [DW-1:0] HRDATA3,
  input  logic          HREADYOUT0,
  input  logic          HREADYOUT1,
  input  logic          HREADYOUT2,
  input  logic          HREADYOUT3,
  input  logic          HRESP0,
  input  logic          HRESP1,
  input  logic          HRESP2,
  input  logic          HRESP3,
  output logic [DW-1:0] HRDATA,
  output logic          HREADY,
  output logic          HRESP
`ifdef AHB_MUX_ERRCNT_EN
  ,
  output logic [15:0]   ERRCNT,
  input  logic          ERRCLR
`endif
);

  dsel_e dsel;
  dsel_e sel_res;
  logic  def_sel;
  logic  def_ready;
  logic  def_resp;

  assign sel_res = resolve_sel({HSEL4, HSEL3, HSEL2, HSEL1, HSEL0});
  // The default slave only sees a transfer that wins priority resolution.
  assign def_sel = (sel_res == DSEL_DEF);

  // Latch the address-phase owner whenever the bus accepts a new address.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dsel <= DSEL_NONE;
    end else if (HREADY) begin
      dsel <= sel_res;
    end
  end

  ahb_default_slave u_default_slave (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .sel       (def_sel),
    .htrans    (HTRANS),
    .hready_in (HREADY),
    .hreadyout (def_ready),
    .hresp     (def_resp)
  );

  // Route the data-phase owner's response straight through to the master.
  always_comb begin
    HRDATA = '0;
    HREADY = 1'b1;
    HRESP  = HRESP_OKAY;
    case (dsel)
      DSEL_S0: begin
        HRDATA = HRDATA0;
        HREADY = HREADYOUT0;
        HRESP  = HRESP0;
      end
      DSEL_S1: begin
        HRDATA = HRDATA1;
        HREADY = HREADYOUT1;
        HRESP  = HRESP1;
      end
      DSEL_S2: begin
        HRDATA = HRDATA2;
        HREADY = HREADYOUT2;
        HRESP  = HRESP2;
      end
      DSEL_S3: begin
        HRDATA = HRDATA3;
        HREADY = HREADYOUT3;
        HRESP  = HRESP3;
      end
      DSEL_DEF: begin
        HRDATA = '0;
        HREADY = def_ready;
        HRESP  = def_resp;
      end
      default: begin
        HRDATA = '0;
        HREADY = 1'b1;
        HRESP  = HRESP_OKAY;
      end
    endcase
  end

`ifdef AHB_MUX_ERRCNT_EN
  logic err_entry;

  // Same condition that moves the default slave into ERR1; it cannot hold
  // while already in ERR1 because the bus is stalled then.
  assign err_entry = def_sel && HREADY &&
                     ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

  // Saturating error counter; clear wins over a simultaneous increment.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ERRCNT <= 16'd0;
    end else if (ERRCLR) begin
      ERRCNT <= 16'd0;
    end else if (err_entry && (ERRCNT != 16'hFFFF)) begin
      ERRCNT <= ERRCNT + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ahb_resp_mux_s5.sv
// Self-checking bench for ahb_resp_mux_s5: directed scenarios then random traffic,
// all compared against a transaction-level model of the data-phase owner.
module tb_ahb_resp_mux_s5;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL0, HSEL1, HSEL2, HSEL3, HSEL4;
  logic [1:0]  HTRANS;
  logic [31:0] HRDATA0, HRDATA1, HRDATA2, HRDATA3;
  logic        HREADYOUT0, HREADYOUT1, HREADYOUT2, HREADYOUT3;
  logic        HRESP0, HRESP1, HRESP2, HRESP3;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
`ifdef AHB_MUX_ERRCNT_EN
  logic [15:0] ERRCNT;
  logic        ERRCLR;
`endif

  always #5 HCLK = ~HCLK;

  ahb_resp_mux_s5 #(.DW(32)) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .HSEL0      (HSEL0),
    .HSEL1      (HSEL1),
    .HSEL2      (HSEL2),
    .HSEL3      (HSEL3),
    .HSEL4      (HSEL4),
    .HTRANS     (HTRANS),
    .HRDATA0    (HRDATA0),
    .HRDATA1    (HRDATA1),
    .HRDATA2    (HRDATA2),
    .HRDATA3    (HRDATA3),
    .HREADYOUT0 (HREADYOUT0),
    .HREADYOUT1 (HREADYOUT1),
    .HREADYOUT2 (HREADYOUT2),
    .HREADYOUT3 (HREADYOUT3),
    .HRESP0     (HRESP0),
    .HRESP1     (HRESP1),
    .HRESP2     (HRESP2),
    .HRESP3     (HRESP3),
    .HRDATA     (HRDATA),
    .HREADY     (HREADY),
    .HRESP      (HRESP)
`ifdef AHB_MUX_ERRCNT_EN
    ,
    .ERRCNT     (ERRCNT),
    .ERRCLR     (ERRCLR)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who owns the data phase (-1 none, 0..3 slaves, 4 default),
  // how far into the two-cycle error response we are (0 none, 1 first, 2 second),
  // and the error count.
  int          m_owner;
  int          m_err_phase;
  int          m_cnt;
  logic [31:0] e_data;
  logic        e_rdy;
  logic        e_resp;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic int lowest_sel();
    logic [4:0] v;
    v = {HSEL4, HSEL3, HSEL2, HSEL1, HSEL0};
    for (int i = 0; i < 5; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner     = -1;
    m_err_phase = 0;
    m_cnt       = 0;
  endtask

  task automatic model_outputs();
    e_data = 32'h0;
    e_rdy  = 1'b1;
    e_resp = 1'b0;
    case (m_owner)
      0: begin e_data = HRDATA0; e_rdy = HREADYOUT0; e_resp = HRESP0; end
      1: begin e_data = HRDATA1; e_rdy = HREADYOUT1; e_resp = HRESP1; end
      2: begin e_data = HRDATA2; e_rdy = HREADYOUT2; e_resp = HRESP2; end
      3: begin e_data = HRDATA3; e_rdy = HREADYOUT3; e_resp = HRESP3; end
      4: begin e_rdy = (m_err_phase != 1); e_resp = (m_err_phase != 0); end
      default: ;
    endcase
  endtask

  // Advance the model across one clock edge using the inputs currently applied.
  task automatic model_edge();
    int s;
    bit err_start;
    s = lowest_sel();
    err_start = (s == 4) && HTRANS[1] && e_rdy;
    if (m_err_phase == 1)  m_err_phase = 2;
    else if (err_start)    m_err_phase = 1;
    else                   m_err_phase = 0;
`ifdef AHB_MUX_ERRCNT_EN
    if (ERRCLR)                          m_cnt = 0;
    else if (err_start && m_cnt < 65535) m_cnt = m_cnt + 1;
`endif
    if (e_rdy) m_owner = s;
  endtask

  // Called at the falling edge: compare against the model, then cross the rising edge.
  task automatic end_cycle(input string tag);
    model_outputs();
    chk({tag, "_rdata"}, HRDATA, e_data);
    chk({tag, "_ready"}, {31'b0, HREADY}, {31'b0, e_rdy});
    chk({tag, "_resp"},  {31'b0, HRESP},  {31'b0, e_resp});
`ifdef AHB_MUX_ERRCNT_EN
    chk({tag, "_errcnt"}, {16'b0, ERRCNT}, m_cnt);
`endif
    model_edge();
    @(posedge HCLK);
    #1;
  endtask

  task automatic step(input string tag);
    @(negedge HCLK);
    end_cycle(tag);
  endtask

  task automatic set_addr(input logic [4:0] sel, input logic [1:0] tr);
    {HSEL4, HSEL3, HSEL2, HSEL1, HSEL0} = sel;
    HTRANS = tr;
  endtask

  initial begin
    HRESETn = 1'b0;
    set_addr(5'b0, 2'd0);
    {HRDATA0, HRDATA1, HRDATA2, HRDATA3} = '0;
    {HREADYOUT0, HREADYOUT1, HREADYOUT2, HREADYOUT3} = 4'hF;
    {HRESP0, HRESP1, HRESP2, HRESP3} = 4'h0;
`ifdef AHB_MUX_ERRCNT_EN
    ERRCLR = 1'b0;
`endif
    model_reset();

    // Reset state
    #3;
    chk("rst_rdata", HRDATA, 32'h0);
    chk("rst_ready", {31'b0, HREADY}, 32'd1);
    chk("rst_resp",  {31'b0, HRESP},  32'd0);
`ifdef AHB_MUX_ERRCNT_EN
    chk("rst_errcnt", {16'b0, ERRCNT}, 32'd0);
`endif
    @(posedge HCLK); @(posedge HCLK); #1;
    HRESETn = 1'b1;

    // Slave 1 read returns its data in the following cycle
    set_addr(5'b00010, 2'd2);
    HRDATA1 = 32'hDEADBEEF;
    step("s1_addr");
    set_addr(5'b0, 2'd0);
    @(negedge HCLK);
    chk("s1_data_rdata", HRDATA, 32'hDEADBEEF);
    chk("s1_data_ready", {31'b0, HREADY}, 32'd1);
    chk("s1_data_resp",  {31'b0, HRESP},  32'd0);
    end_cycle("s1_data");

    // Slave 2 stalls for three cycles while slave 0 waits in the address phase
    HRDATA2 = 32'h22222222;
    HRDATA0 = 32'h00000A0A;
    set_addr(5'b00100, 2'd2);
    step("s2_addr");
    set_addr(5'b00001, 2'd2);
    HREADYOUT2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      chk("s2_stall_rdata", HRDATA, 32'h22222222);
      chk("s2_stall_ready", {31'b0, HREADY}, 32'd0);
      end_cycle("s2_stall");
    end
    HREADYOUT2 = 1'b1;
    @(negedge HCLK);
    chk("s2_done_rdata", HRDATA, 32'h22222222);
    end_cycle("s2_done");
    set_addr(5'b0, 2'd0);
    @(negedge HCLK);
    chk("s0_after_rdata", HRDATA, 32'h00000A0A);
    end_cycle("s0_after");

    // Default slave: back-to-back NONSEQ gives two full error responses
    set_addr(5'b10000, 2'd2);
    step("def_addr");
    @(negedge HCLK);
    chk("def_e1_ready", {31'b0, HREADY}, 32'd0);
    chk("def_e1_resp",  {31'b0, HRESP},  32'd1);
    end_cycle("def_e1");
    @(negedge HCLK);
    chk("def_e2_ready", {31'b0, HREADY}, 32'd1);
    chk("def_e2_resp",  {31'b0, HRESP},  32'd1);
    end_cycle("def_e2");
    set_addr(5'b0, 2'd0);
    @(negedge HCLK);
    chk("def_b2b_e1_ready", {31'b0, HREADY}, 32'd0);
    chk("def_b2b_e1_resp",  {31'b0, HRESP},  32'd1);
    end_cycle("def_b2b_e1");
    @(negedge HCLK);
    chk("def_b2b_e2_ready", {31'b0, HREADY}, 32'd1);
    chk("def_b2b_e2_resp",  {31'b0, HRESP},  32'd1);
    end_cycle("def_b2b_e2");
    @(negedge HCLK);
    chk("def_done_resp", {31'b0, HRESP}, 32'd0);
    end_cycle("def_done");

    // Default slave with an IDLE transfer: zero-wait OKAY
    set_addr(5'b10000, 2'd0);
    step("def_idle_addr");
    set_addr(5'b0, 2'd0);
    @(negedge HCLK);
    chk("def_idle_ready", {31'b0, HREADY}, 32'd1);
    chk("def_idle_resp",  {31'b0, HRESP},  32'd0);
    chk("def_idle_rdata", HRDATA, 32'h0);
    end_cycle("def_idle");

    // Reset pulsed during ERR1 takes effect without a clock edge
    set_addr(5'b10000, 2'd3);
    step("rst_err_addr");
    set_addr(5'b0, 2'd0);
    @(negedge HCLK);
    chk("rst_err_pre_ready", {31'b0, HREADY}, 32'd0);
    #1 HRESETn = 1'b0;
    #1;
    chk("rst_err_rdata", HRDATA, 32'h0);
    chk("rst_err_ready", {31'b0, HREADY}, 32'd1);
    chk("rst_err_resp",  {31'b0, HRESP},  32'd0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    model_reset();
    @(negedge HCLK);
    chk("rst_err_after_ready", {31'b0, HREADY}, 32'd1);
    chk("rst_err_after_resp",  {31'b0, HRESP},  32'd0);
    end_cycle("rst_err_after");

`ifdef AHB_MUX_ERRCNT_EN
    // Three errors counted, then clear wins over a simultaneous ERR1 entry
    for (int i = 0; i < 3; i++) begin
      set_addr(5'b10000, 2'd2);
      step("cnt_addr");
      set_addr(5'b0, 2'd0);
      step("cnt_e1");
      step("cnt_e2");
    end
    @(negedge HCLK);
    chk("cnt_three", {16'b0, ERRCNT}, 32'd3);
    end_cycle("cnt_chk");
    set_addr(5'b10000, 2'd2);
    ERRCLR = 1'b1;
    step("cnt_clr_addr");
    ERRCLR = 1'b0;
    set_addr(5'b0, 2'd0);
    @(negedge HCLK);
    chk("cnt_clr", {16'b0, ERRCNT}, 32'd0);
    end_cycle("cnt_clr_e1");
    step("cnt_clr_e2");
`endif

    // Random traffic with random stalls, priorities and responses
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] sel;
      if ($urandom_range(3) == 0) sel = 5'($urandom);
      else if ($urandom_range(5) == 0) sel = 5'b0;
      else sel = 5'(1 << $urandom_range(4));
      set_addr(sel, 2'($urandom));
      HRDATA0 = $urandom; HRDATA1 = $urandom;
      HRDATA2 = $urandom; HRDATA3 = $urandom;
      HREADYOUT0 = ($urandom_range(3) != 0);
      HREADYOUT1 = ($urandom_range(3) != 0);
      HREADYOUT2 = ($urandom_range(3) != 0);
      HREADYOUT3 = ($urandom_range(3) != 0);
      {HRESP0, HRESP1, HRESP2, HRESP3} = 4'($urandom);
`ifdef AHB_MUX_ERRCNT_EN
      ERRCLR = ($urandom_range(15) == 0);
`endif
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
